muldiv_hilo: RTL and testbench

Iterative multiply/divide unit with the HI/LO architectural registers, in the execute stage next to the ALU. It takes the same two register-file operands the ALU takes, and serves the MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions. It presents HI and LO continuously to the writeback result mux, where they are selected for MFHI and MFLO. The CPU control stalls issue while `busy` is high.

---
 rtl/muldiv_hilo.sv | 148 ++++++++++++++
 tb/tb_muldiv_hilo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Iterative MIPS multiply/divide unit holding the HI/LO architectural registers.
// Shift-add multiply and restoring divide, one bit per cycle, 32 cycles per operation.
module muldiv_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_bz;
  logic [31:0] r_a_raw;
  logic [63:0] r_prod;
  logic [31:0] r_mcand;
  logic [31:0] r_rem;
  logic [31:0] r_quo;

  logic        w_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_sum;
  logic [63:0] w_prod_nxt;
  logic [63:0] w_prod_fix;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic        w_last;

  // Even op codes (MULT, DIV) are the signed variants.
  assign w_sgn   = ~op[0];
  assign w_a_neg = w_sgn & a[31];
  assign w_b_neg = w_sgn & b[31];
  assign w_a_mag = w_a_neg ? (~a + 32'd1) : a;
  assign w_b_mag = w_b_neg ? (~b + 32'd1) : b;

  // r_prod holds {partial sum, remaining multiplier bits}; shifts right each step.
  assign w_sum      = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_mcand : 32'd0)};
  assign w_prod_nxt = {w_sum, r_prod[31:1]};
  assign w_prod_fix = r_neg_q ? (~w_prod_nxt + 64'd1) : w_prod_nxt;

  // Divide by zero is overridden at the end, so the trial borrow need not be exact there.
  assign w_trial   = {r_rem, r_quo[31]} - {1'b0, r_mcand};
  assign w_qbit    = ~w_trial[32];
  assign w_rem_nxt = w_qbit ? w_trial[31:0] : {r_rem[30:0], r_quo[31]};
  assign w_quo_nxt = {r_quo[30:0], w_qbit};
  assign w_q_fix   = r_neg_q ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  assign w_last = (r_cnt == 6'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_a_raw <= 32'd0;
      r_prod  <= 64'd0;
      r_mcand <= 32'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                r_state <= MUL;
                r_busy  <= 1'b1;
                r_cnt   <= 6'd0;
                r_prod  <= {32'd0, w_b_mag};
                r_mcand <= w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
              end
              3'd2, 3'd3: begin
                r_state <= DIV;
                r_busy  <= 1'b1;
                r_cnt   <= 6'd0;
                r_rem   <= 32'd0;
                r_quo   <= w_a_mag;
                r_mcand <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_bz    <= (b == 32'd0);
                r_a_raw <= a;
              end
              3'd4:    r_hi <= a;
              3'd5:    r_lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 6'd1;
          if (w_last) begin
            r_hi    <= w_prod_fix[63:32];
            r_lo    <= w_prod_fix[31:0];
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_hi    <= r_bz ? r_a_raw : w_r_fix;
            r_lo    <= r_bz ? 32'hFFFF_FFFF : w_q_fix;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized operations.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_hilo dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: {hi, lo} an operation must produce, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    case (o)
      3'd0: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_left = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_left = 0;
      chk_en = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (start) begin
      case (op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          m_pend = ref_result(op, a, b);
          m_left = 32;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_total++;
      if (busy === (m_left > 0) && hi === m_hi && lo === m_lo) n_pass++;
      else $display("FAIL cycle t=%0t: busy=%b hi=%h lo=%h expected busy=%b hi=%h lo=%h",
                    $time, busy, hi, lo, (m_left > 0), m_hi, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_idle_timeout", 64'(n), 64'd32);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_after_start", 64'(busy), 64'd1);
    check("multu_hi_held", 64'(hi), 64'd0);
    wait_idle(n);
    check("multu_busy_cycles", 64'(n), 64'd32);
    check("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    check("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h0000_0000_1234_5678);
    check("mthi_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_neg7_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_neg7_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi", 64'(hi), 64'd0);

    issue(3'd3, 32'h0000_1234, 32'd0);
    wait_idle(n);
    check("divu0_busy_cycles", 64'(n), 64'd32);
    check("divu0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("divu0_hi", 64'(hi), 64'h0000_0000_0000_1234);
    issue(3'd2, 32'd7, 32'd0);
    wait_idle(n);
    check("div0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("div0_hi", 64'(hi), 64'd7);

    // Requests and operand changes while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (busy === 1'b1 && k < 100) begin
      a = $urandom;
      b = $urandom;
      if (k == 5)  begin start = 1'b1; op = 3'd1; end
      if (k == 6)  start = 1'b0;
      if (k == 20) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; end
      if (k == 21) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check("ign_busy_cycles", 64'(k), 64'd33);
    check("ign_lo", 64'(lo), 64'd14);
    check("ign_hi", 64'(hi), 64'd2);
    @(negedge clk);
    check("ign_no_queue", 64'(busy), 64'd0);

    // start held high: ignored at E32, accepted at E33.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    op = 3'd1; a = 32'd6; b = 32'd7;
    wait_idle(n);
    check("b2b_first_cycles", 64'(n), 64'd32);
    check("b2b_first_lo", 64'(lo), 64'd14);
    @(negedge clk);
    check("b2b_accepted", 64'(busy), 64'd1);
    start = 1'b0;
    wait_idle(n);
    check("b2b_second_cycles", 64'(n), 64'd32);
    check("b2b_second_lo", 64'(lo), 64'd42);
    check("b2b_second_hi", 64'(hi), 64'd0);

    // Reset partway through a multiply.
    issue(3'd1, 32'h0001_2345, 32'h0000_6789);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    issue(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    check("after_rst_lo", 64'(lo), 64'd12);
    check("after_rst_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      issue(ro, pick(), pick());
      if (busy === 1'b1) wait_idle(n);
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
